// File: rtl/add_share_pkg.sv
`default_nettype none
// =============================================================================
// add_share_pkg : shared state encoding and default sizes  |  rev 1.0
// =============================================================================
package add_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int N_REQ_DEF = 4;
    localparam int W_DEF     = 8;
    localparam int CNTW_DEF  = 8;

endpackage
`default_nettype wire

// File: rtl/rr_picker.sv
`default_nettype none
// =============================================================================
// rr_picker : combinational round-robin one-hot select from rr_ptr  |  rev 1.0
// =============================================================================
module rr_picker #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] rr_ptr,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] grant_idx,
    output logic                     any_req
);

    localparam int IDW = $clog2(N_REQ);

    always_comb begin
        int                 j;
        logic [IDW-1:0]     idx;
        j         = 0;
        idx       = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        grant     = '0;
        // Walk from the farthest offset down so the nearest request to rr_ptr wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            idx = IDW'(j);
            if (req[idx]) begin
                grant_idx = idx;
                any_req   = 1'b1;
            end
        end
        if (any_req) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/add_share_arbiter.sv
`default_nettype none
// =============================================================================
// add_share_arbiter : N_REQ requesters share one registered W-bit adder  |  rev 1.0
// =============================================================================
module add_share_arbiter
    import add_share_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int W     = W_DEF,
    parameter int CNTW  = CNTW_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ena,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*W-1:0]       req_a,
    input  logic [N_REQ*W-1:0]       req_b,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [$clog2(N_REQ)-1:0] rsp_id,
    output logic [W-1:0]             rsp_sum,
    output logic                     rsp_carry,
    output logic                     busy,
    output logic [CNTW-1:0]          op_count
);

    localparam int             IDW     = $clog2(N_REQ);
    localparam logic [IDW-1:0] LAST_ID = IDW'(N_REQ - 1);

    state_t          state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [IDW-1:0]  rsp_id_q, rsp_id_d;
    logic [W-1:0]    rsp_sum_q, rsp_sum_d;
    logic            rsp_carry_q, rsp_carry_d;
    logic [CNTW-1:0] op_count_q, op_count_d;

    logic [N_REQ-1:0] pick_grant;
    logic [IDW-1:0]   pick_idx;
    logic             pick_any;

    rr_picker #(
        .N_REQ (N_REQ)
    ) u_picker (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any_req   (pick_any)
    );

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        rsp_id_d    = rsp_id_q;
        rsp_sum_d   = rsp_sum_q;
        rsp_carry_d = rsp_carry_q;
        op_count_d  = op_count_q;
        req_ready   = '0;
        case (state_q)
            IDLE: begin
                // The picker only returns valid requesters, so a visible grant is an accept.
                if (ena && pick_any) begin
                    req_ready = pick_grant;
                    a_d       = req_a[pick_idx*W +: W];
                    b_d       = req_b[pick_idx*W +: W];
                    id_d      = pick_idx;
                    state_d   = CALC;
                end
            end
            CALC: begin
                if (ena) begin
                    {rsp_carry_d, rsp_sum_d} = {1'b0, a_q} + {1'b0, b_q};
                    rsp_id_d = id_q;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (ena && rsp_ready) begin
                    state_d  = IDLE;
                    rr_ptr_d = (id_q == LAST_ID) ? '0 : id_q + IDW'(1);
                    if (op_count_q != '1) begin
                        op_count_d = op_count_q + CNTW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            rsp_id_q    <= '0;
            rsp_sum_q   <= '0;
            rsp_carry_q <= 1'b0;
            op_count_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            rsp_id_q    <= rsp_id_d;
            rsp_sum_q   <= rsp_sum_d;
            rsp_carry_q <= rsp_carry_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign busy      = (state_q != IDLE);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_carry = rsp_carry_q;
    assign op_count  = op_count_q;

endmodule
`default_nettype wire

// File: tb/tb_add_share_arbiter.sv
`default_nettype none
// =============================================================================
// tb_add_share_arbiter : directed self-checking bench for add_share_arbiter  |  rev 1.0
// =============================================================================
module tb_add_share_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ena;
    logic [3:0]  req_valid;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_ready;

    logic [3:0]  req_ready;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [7:0]  rsp_sum;
    logic        rsp_carry;
    logic        busy;
    logic [7:0]  op_count;

    logic [3:0]  c4_req_ready;
    logic        c4_rsp_valid;
    logic [1:0]  c4_rsp_id;
    logic [7:0]  c4_rsp_sum;
    logic        c4_rsp_carry;
    logic        c4_busy;
    logic [3:0]  c4_op_count;

    int errors = 0;
    int checks = 0;
    int exp_count = 0;

    logic [7:0] f_a   [0:3] = '{8'h11, 8'h22, 8'h33, 8'hC4};
    logic [7:0] f_b   [0:3] = '{8'h01, 8'h10, 8'hF0, 8'h50};
    logic [7:0] f_sum [0:3] = '{8'h12, 8'h32, 8'h23, 8'h14};
    logic       f_c   [0:3] = '{1'b0, 1'b0, 1'b1, 1'b1};

    always #5 clk = ~clk;

    add_share_arbiter #(.N_REQ(4), .W(8), .CNTW(8)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_carry(rsp_carry),
        .busy(busy), .op_count(op_count)
    );

    // Narrow-counter copy sharing all stimulus, used for saturation.
    add_share_arbiter #(.N_REQ(4), .W(8), .CNTW(4)) dut_c4 (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(c4_req_ready), .rsp_valid(c4_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(c4_rsp_id), .rsp_sum(c4_rsp_sum), .rsp_carry(c4_rsp_carry),
        .busy(c4_busy), .op_count(c4_op_count)
    );

    task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[i*8 +: 8] = a;
        req_b[i*8 +: 8] = b;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; ena = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy, op_count} !== 25'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {req_ready, rsp_valid, rsp_id, rsp_sum, rsp_carry, busy, op_count});
        end
        checks++;
        if ({c4_op_count, c4_rsp_valid, c4_busy} !== 6'd0) begin
            errors++;
            $display("FAIL reset_c4: got %b expected 0", {c4_op_count, c4_rsp_valid, c4_busy});
        end
        step();
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy, rsp_valid, req_ready} !== 6'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b expected 000000", {busy, rsp_valid, req_ready});
        end
        step();
    endtask

    task automatic test_single();
        set_op(2, 8'h3C, 8'h05);
        req_valid = 4'b0100; rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL single_grant: req_ready=%b expected 0100", req_ready);
        end
        step();
        req_valid = '0;
        @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, busy} !== 6'b0000_01) begin
            errors++; $display("FAIL single_calc: {req_ready,rsp_valid,busy}=%b expected 000001", {req_ready, rsp_valid, busy});
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'd2, 8'h41, 1'b0}) begin
            errors++; $display("FAIL single_resp: v=%b id=%0d sum=%h c=%b expected 1 2 41 0", rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_count = 1;
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy, op_count, rsp_sum} !== {1'b0, 1'b0, 8'd1, 8'h41}) begin
            errors++; $display("FAIL single_done: v=%b busy=%b cnt=%0d sum=%h expected 0 0 1 41", rsp_valid, busy, op_count, rsp_sum);
        end
        step();
    endtask

    task automatic test_overflow();
        set_op(0, 8'hFF, 8'h02);
        req_valid = 4'b0001; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL ovf_grant: req_ready=%b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'd0, 8'h01, 1'b1}) begin
            errors++; $display("FAIL ovf_resp: v=%b id=%0d sum=%h c=%b expected 1 0 01 1", rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
        step();
        rsp_ready = 1'b0;
        exp_count = 2;
        @(negedge clk);
        checks++;
        if (op_count !== 8'(exp_count) || busy !== 1'b0) begin
            errors++; $display("FAIL ovf_count: cnt=%0d busy=%b expected %0d 0", op_count, busy, exp_count);
        end
        step();
    endtask

    task automatic test_fairness();
        for (int i = 0; i < 4; i++) set_op(i, f_a[i], f_b[i]);
        // Service requester 3 alone first so rr_ptr wraps to 0.
        req_valid = 4'b1000; rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL fair_pre_grant: req_ready=%b expected 1000", req_ready);
        end
        step();
        req_valid = 4'b1111;
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'd3, 8'h14, 1'b1}) begin
            errors++; $display("FAIL fair_pre_resp: v=%b id=%0d sum=%h c=%b expected 1 3 14 1", rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
        step();
        exp_count++;
        for (int k = 0; k < 6; k++) begin
            int         e;
            logic [3:0] oh;
            e  = k % 4;
            oh = 4'b0001 << e;
            @(negedge clk);
            checks++;
            if (req_ready !== oh) begin
                errors++; $display("FAIL fair_grant[%0d]: req_ready=%b expected %b", k, req_ready, oh);
            end
            step();
            @(negedge clk);
            checks++;
            if ({req_ready, busy, rsp_valid} !== 6'b0000_10) begin
                errors++; $display("FAIL fair_calc[%0d]: {req_ready,busy,rsp_valid}=%b expected 000010", k, {req_ready, busy, rsp_valid});
            end
            step();
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, req_ready} !== {1'b1, 2'(e), f_sum[e], f_c[e], 4'b0000}) begin
                errors++; $display("FAIL fair_resp[%0d]: v=%b id=%0d sum=%h c=%b rdy=%b expected 1 %0d %h %b 0000",
                                   k, rsp_valid, rsp_id, rsp_sum, rsp_carry, req_ready, e, f_sum[e], f_c[e]);
            end
            step();
            exp_count++;
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (op_count !== 8'(exp_count)) begin
            errors++; $display("FAIL fair_count: cnt=%0d expected %0d", op_count, exp_count);
        end
        step();
    endtask

    task automatic test_backpressure();
        set_op(3, 8'h80, 8'h80);
        req_valid = 4'b1000; rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b1000) begin
            errors++; $display("FAIL bp_grant: req_ready=%b expected 1000", req_ready);
        end
        step();
        req_valid = 4'b1001;
        step();
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, rsp_id, rsp_sum, rsp_carry, req_ready, busy} !== {1'b1, 2'd3, 8'h00, 1'b1, 4'b0000, 1'b1}) begin
                errors++; $display("FAIL bp_hold[%0d]: v=%b id=%0d sum=%h c=%b rdy=%b busy=%b expected 1 3 00 1 0000 1",
                                   n, rsp_valid, rsp_id, rsp_sum, rsp_carry, req_ready, busy);
            end
            step();
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_count++;
        // rr_ptr now 0: requester 0 must win over requester 3.
        @(negedge clk);
        checks++;
        if ({busy, req_ready, op_count} !== {1'b0, 4'b0001, 8'(exp_count)}) begin
            errors++; $display("FAIL bp_release: busy=%b rdy=%b cnt=%0d expected 0 0001 %0d", busy, req_ready, op_count, exp_count);
        end
        step();
        req_valid = '0;
        rsp_ready = 1'b1;
        step();
        step();
        rsp_ready = 1'b0;
        exp_count++;
    endtask

    task automatic test_ena();
        set_op(0, 8'h12, 8'h34);
        req_valid = 4'b0001;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0001) begin
            errors++; $display("FAIL ena_grant: req_ready=%b expected 0001", req_ready);
        end
        step();
        req_valid = '0;
        ena = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            checks++;
            if ({busy, rsp_valid, req_ready} !== 6'b10_0000) begin
                errors++; $display("FAIL ena_frozen[%0d]: {busy,v,rdy}=%b expected 100000", n, {busy, rsp_valid, req_ready});
            end
            step();
        end
        ena = 1'b1;
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL ena_still_calc: v=%b expected 0", rsp_valid);
        end
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_id, rsp_sum, rsp_carry} !== {1'b1, 2'd0, 8'h46, 1'b0}) begin
            errors++; $display("FAIL ena_resp: v=%b id=%0d sum=%h c=%b expected 1 0 46 0", rsp_valid, rsp_id, rsp_sum, rsp_carry);
        end
        ena = 1'b0;
        rsp_ready = 1'b1;
        step();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_sum, op_count} !== {1'b1, 8'h46, 8'(exp_count)}) begin
            errors++; $display("FAIL ena_resp_hold: v=%b sum=%h cnt=%0d expected 1 46 %0d", rsp_valid, rsp_sum, op_count, exp_count);
        end
        ena = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_count++;
        @(negedge clk);
        checks++;
        if ({busy, op_count} !== {1'b0, 8'(exp_count)}) begin
            errors++; $display("FAIL ena_done: busy=%b cnt=%0d expected 0 %0d", busy, op_count, exp_count);
        end
        step();
        ena = 1'b0;
        req_valid = 4'b0100;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0000) begin
            errors++; $display("FAIL ena_idle_ready: req_ready=%b expected 0000", req_ready);
        end
        step();
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL ena_idle_noaccept: busy=%b expected 0", busy);
        end
        step();
        req_valid = '0;
        ena = 1'b1;
    endtask

    task automatic test_reset_async();
        set_op(2, 8'h01, 8'h01);
        req_valid = 4'b0100; rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if (req_ready !== 4'b0100) begin
            errors++; $display("FAIL rst_grant: req_ready=%b expected 0100", req_ready);
        end
        step();
        req_valid = '0;
        step();
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++; $display("FAIL rst_in_resp: v=%b expected 1", rsp_valid);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy, op_count, c4_op_count} !== 14'd0) begin
            errors++; $display("FAIL rst_async: v=%b busy=%b cnt=%0d c4cnt=%0d expected 0 0 0 0", rsp_valid, busy, op_count, c4_op_count);
        end
        step();
        rst_n = 1'b1;
        exp_count = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            checks++;
            if ({rsp_valid, busy} !== 2'b00) begin
                errors++; $display("FAIL rst_no_resp[%0d]: {v,busy}=%b expected 00", n, {rsp_valid, busy});
            end
            step();
        end
    endtask

    task automatic test_saturation();
        set_op(1, 8'h07, 8'h08);
        req_valid = 4'b0010; rsp_ready = 1'b1;
        for (int op = 1; op <= 17; op++) begin
            repeat (3) step();
            if (op == 14) begin
                checks++;
                if (c4_op_count !== 4'hE) begin
                    errors++; $display("FAIL sat_14: c4cnt=%h expected E", c4_op_count);
                end
            end
            if (op == 15) begin
                checks++;
                if (c4_op_count !== 4'hF) begin
                    errors++; $display("FAIL sat_15: c4cnt=%h expected F", c4_op_count);
                end
            end
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++;
        if ({c4_op_count, op_count, rsp_sum} !== {4'hF, 8'd17, 8'h0F}) begin
            errors++; $display("FAIL sat_17: c4cnt=%h cnt=%0d sum=%h expected F 17 0F", c4_op_count, op_count, rsp_sum);
        end
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_overflow();
        test_fairness();
        test_backpressure();
        test_ena();
        test_reset_async();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
